// File: rtl/if_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_fetch : instruction-fetch stage, one SRAM request in flight, AdEL,     |
// |            decode redirect and writeback flush.          Revision: 1.0    |
// +--------------------------------------------------------------------------+
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin_in,
  input  logic [31:0] id_nextPC_in,
  input  logic        wb_ClrStpJmp_in,
  input  logic [31:0] wb_cp0_res_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_NPC_fast_out,
  output logic [31:0] if_Instruct_out,
  output logic        if_exception_out,
  output logic [4:0]  if_ExcCode_out,
  output logic [31:0] if_error_VAddr_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [4:0] C_EXC_ADEL = 5'h04;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic        r_cancel;
  logic        w_cancel_nxt;
  logic        w_load_inst;
  logic        w_load_adel;
  logic        w_aligned;
  logic        w_addr_hs;
  logic        w_fire;

  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_nnpc;
  logic [31:0] r_instr;
  logic        r_exc;
  logic [4:0]  r_exccode;
  logic [31:0] r_evaddr;

  assign w_aligned    = (r_fetch_pc[1:0] == 2'b00);
  assign inst_req     = (r_state == REQ) && w_aligned;
  assign inst_addr    = r_fetch_pc;
  assign w_addr_hs    = inst_req && inst_addr_ok;
  assign if_valid_out = (r_state == HOLD);
  assign w_fire       = if_valid_out && id_allowin_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_cancel   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_cancel   <= w_cancel_nxt;
    end
  end

  // Flush overrides everything: it always retargets fetch_pc, and any
  // request already accepted by the SRAM is marked stale instead of aborted.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_cancel_nxt   = r_cancel;
    w_load_inst    = 1'b0;
    w_load_adel    = 1'b0;
    if (wb_ClrStpJmp_in) begin
      w_fetch_pc_nxt = wb_cp0_res_in;
    end
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
      end
      REQ: begin
        if (!w_aligned) begin
          if (!wb_ClrStpJmp_in) begin
            w_load_adel = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (w_addr_hs) begin
          w_state_nxt  = WAIT;
          w_cancel_nxt = wb_ClrStpJmp_in;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          w_cancel_nxt = 1'b0;
          if (r_cancel || wb_ClrStpJmp_in) begin
            w_state_nxt = REQ;
          end else begin
            w_load_inst = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (wb_ClrStpJmp_in) begin
          w_cancel_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (wb_ClrStpJmp_in) begin
          w_state_nxt = REQ;
        end else if (w_fire) begin
          w_fetch_pc_nxt = id_nextPC_in;
          w_state_nxt    = REQ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= 32'h0;
      r_npc     <= 32'h0;
      r_nnpc    <= 32'h0;
      r_instr   <= 32'h0;
      r_exc     <= 1'b0;
      r_exccode <= 5'h0;
      r_evaddr  <= 32'h0;
    end else if (w_load_inst || w_load_adel) begin
      r_pc      <= r_fetch_pc;
      r_npc     <= r_fetch_pc + 32'd4;
      r_nnpc    <= r_fetch_pc + 32'd8;
      r_instr   <= w_load_inst ? inst_rdata : 32'h0;
      r_exc     <= w_load_adel;
      r_exccode <= w_load_adel ? C_EXC_ADEL : 5'h0;
      r_evaddr  <= w_load_adel ? r_fetch_pc : 32'h0;
    end
  end

  assign if_PC_out          = r_pc;
  assign if_NPC_out         = r_npc;
  assign if_NNPC_out        = r_nnpc;
  assign if_NPC_fast_out    = r_pc + 32'd4;
  assign if_Instruct_out    = r_instr;
  assign if_exception_out   = r_exc;
  assign if_ExcCode_out     = r_exccode;
  assign if_error_VAddr_out = r_evaddr;

endmodule
`default_nettype wire
